// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multi-cycle MIPS-style datapath
// Optional performance counters (CYCLE_CNT, INSTR_CNT) are built when MCTRL_PERF_CNT_EN is defined.
module multicycle_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [5:0]  OPCODE,
    input  logic        MEM_READY,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  STATE,
    output logic        ILLEGAL
`ifdef MCTRL_PERF_CNT_EN
    ,
    output logic [31:0] CYCLE_CNT,
    output logic [31:0] INSTR_CNT
`endif
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_RX   = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IX   = 4'd10,
        S_IWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state;
    state_t state_next;
    logic   mem_is_sw;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IF;
        end else begin
            state <= state_next;
        end
    end

    // Load/store class is captured in ID so later OPCODE changes cannot redirect MADR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_is_sw <= 1'b0;
        end else if (state == S_ID) begin
            mem_is_sw <= (OPCODE == OP_SW);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IF:   state_next = MEM_READY ? S_ID : S_IF;
            S_ID: begin
                case (OPCODE)
                    OP_RTYPE:      state_next = S_RX;
                    OP_LW, OP_SW:  state_next = S_MADR;
                    OP_BEQ:        state_next = S_BR;
                    OP_J:          state_next = S_JMP;
                    OP_ADDI:       state_next = S_IX;
                    default:       state_next = S_IF;
                endcase
            end
            S_MADR: state_next = mem_is_sw ? S_MWR : S_MRD;
            S_MRD:  state_next = MEM_READY ? S_MWB : S_MRD;
            S_MWR:  state_next = MEM_READY ? S_IF : S_MWR;
            S_RX:   state_next = S_RWB;
            S_IX:   state_next = S_IWB;
            S_MWB, S_RWB, S_IWB, S_BR, S_JMP: state_next = S_IF;
            default: state_next = S_IF;
        endcase
    end

    // Outputs are forced low while RST_N is low, independent of the clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        ILLEGAL     = 1'b0;
        if (RST_N) begin
            case (state)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MEM_READY;
                    PCWrite = MEM_READY;
                end
                S_ID: begin
                    ALUSrcB = 2'b11;
                    case (OPCODE)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ILLEGAL = 1'b0;
                        default: ILLEGAL = 1'b1;
                    endcase
                end
                S_MADR, S_IX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BR: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_IWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign STATE = state;

`ifdef MCTRL_PERF_CNT_EN
    logic instr_done;

    // Only completed instructions count; the ID->IF return of an illegal opcode does not.
    always_comb begin
        instr_done = 1'b0;
        if (state_next == S_IF) begin
            case (state)
                S_MWB, S_RWB, S_IWB, S_MWR, S_BR, S_JMP: instr_done = 1'b1;
                default: instr_done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CYCLE_CNT <= 32'd0;
            INSTR_CNT <= 32'd0;
        end else begin
            CYCLE_CNT <= CYCLE_CNT + 32'd1;
            if (instr_done) begin
                INSTR_CNT <= INSTR_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [5:0]  OPCODE;
    logic        MEM_READY;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  STATE;
    logic        ILLEGAL;
`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] CYCLE_CNT, INSTR_CNT;
`endif

    multicycle_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .STATE(STATE), .ILLEGAL(ILLEGAL)
`ifdef MCTRL_PERF_CNT_EN
        , .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
`endif
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca;
        logic [1:0] psrc, aluop, srcb;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic [3:0] state;
        outs_t      outs;
    } sb_t;

    typedef struct {
        logic [5:0]       opcode;
        int               if_stall;
        int               mem_stall;
        bit               illegal;
        int               len;
        logic [0:5][3:0]  path;
    } vec_t;

    outs_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, ILLEGAL};

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   fails = 0;
    int   cyc_count = 0;
    int   exp_instr = 0;

    function automatic outs_t exp_out(logic [3:0] s, logic mr, bit ill);
        outs_t o;
        o = '0;
        case (s)
            4'd0:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd1:  begin o.srcb = 2'b11; o.ill = ill; end
            4'd2, 4'd10: begin o.srca = 1; o.srcb = 2'b10; end
            4'd3:  begin o.mrd = 1; o.iord = 1; end
            4'd4:  begin o.rw = 1; o.m2r = 1; end
            4'd5:  begin o.mwr = 1; o.iord = 1; end
            4'd6:  begin o.srca = 1; o.aluop = 2'b10; end
            4'd7:  begin o.rw = 1; o.rdst = 1; end
            4'd8:  begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.psrc = 2'b01; end
            4'd9:  begin o.pcw = 1; o.psrc = 2'b10; end
            4'd11: o.rw = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(string name, logic [31:0] actual, logic [31:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, actual, required);
        end
    endtask

    // Drive one cycle, push its expectation, compare at the falling edge.
    task automatic do_cycle(logic [3:0] s, logic mr, logic [5:0] op, bit ill);
        sb_t e;
        MEM_READY = mr;
        OPCODE    = op;
        sb_q.push_back({s, exp_out(s, mr, ill)});
        @(negedge CLK);
        e = sb_q.pop_front();
        check("state", 32'(STATE), 32'(e.state));
        check("outputs", 32'(act), 32'(e.outs));
        @(posedge CLK);
        #1;
        cyc_count++;
    endtask

    task automatic run_vec(vec_t v);
        logic [3:0] s;
        int         reps;
        bit         waits;
        logic       mr;
        logic [5:0] op;
        for (int k = 0; k < v.len; k++) begin
            s     = v.path[k];
            waits = (s == 4'd0) || (s == 4'd3) || (s == 4'd5);
            reps  = 1 + ((s == 4'd0) ? v.if_stall : ((s == 4'd3 || s == 4'd5) ? v.mem_stall : 0));
            for (int i = 0; i < reps; i++) begin
                mr = waits ? logic'(i == reps - 1) : 1'($urandom_range(0, 1));
                op = (s == 4'd1) ? v.opcode : 6'($urandom_range(0, 63));
                do_cycle(s, mr, op, v.illegal);
            end
        end
        if (!v.illegal) exp_instr++;
    endtask

    initial begin
        vecs[0] = '{6'b100011, 0, 0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}};
        vecs[1] = '{6'b001000, 0, 0, 1'b0, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0}};
        vecs[2] = '{6'b000100, 0, 0, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}};
        vecs[3] = '{6'b000010, 0, 0, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}};
        vecs[4] = '{6'b101011, 2, 1, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}};
        vecs[5] = '{6'b000000, 1, 0, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}};
        vecs[6] = '{6'b111111, 0, 0, 1'b1, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
        vecs[7] = '{6'b100011, 1, 3, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}};
        vecs[8] = '{6'b000001, 2, 0, 1'b1, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
        vecs[9] = '{6'b101011, 0, 0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}};

        RST_N     = 1'b0;
        MEM_READY = 1'b1;
        OPCODE    = 6'b100011;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 32'(STATE), 32'd0);
        check("reset_outputs", 32'(act), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
        check("reset_cycle_cnt", CYCLE_CNT, 32'd0);
        check("reset_instr_cnt", INSTR_CNT, 32'd0);
`endif
        RST_N = 1'b1;

        for (int n = 0; n < 10; n++) begin
            run_vec(vecs[n]);
`ifdef MCTRL_PERF_CNT_EN
            if (n == 1) begin
                check("lw_addi_cycle_cnt", CYCLE_CNT, 32'd9);
                check("lw_addi_instr_cnt", INSTR_CNT, 32'd2);
            end
`endif
        end
        check("back_in_if", 32'(STATE), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
        check("total_cycle_cnt", CYCLE_CNT, 32'(cyc_count));
        check("total_instr_cnt", INSTR_CNT, 32'(exp_instr));
`endif

        // Reset asserted in the middle of a stalled MRD must clear everything without a clock edge.
        do_cycle(4'd0, 1'b1, 6'd0, 1'b0);
        do_cycle(4'd1, 1'b1, 6'b100011, 1'b0);
        do_cycle(4'd2, 1'b1, 6'b101011, 1'b0);
        MEM_READY = 1'b0;
        #1;
        check("mrd_state", 32'(STATE), 32'd3);
        check("mrd_memread", 32'(MemRead), 32'd1);
        RST_N = 1'b0;
        #1;
        check("async_reset_state", 32'(STATE), 32'd0);
        check("async_reset_outputs", 32'(act), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
        check("async_reset_cycle_cnt", CYCLE_CNT, 32'd0);
`endif
        MEM_READY = 1'b1;
        @(posedge CLK);
        #1;
        check("held_reset_state", 32'(STATE), 32'd0);
        check("held_reset_outputs", 32'(act), 32'd0);
        RST_N = 1'b1;
        run_vec(vecs[7]);
        run_vec(vecs[3]);
        check("final_state", 32'(STATE), 32'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- OPCODE  in  6  instr[31:26] from the instruction register
- MEM_READY  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath enables and selects
- PCSource  out  2  PC source select: 00 ALU, 01 ALUOut, 10 jump target
- ALUOp  out  2  ALU op class: 00 add, 01 sub, 10 funct
- ALUSrcB  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- STATE  out  4  current FSM state, for debug
- ILLEGAL  out  1  unsupported opcode decoded in ID

REQ-002 SHALL have one clock domain (CLK); reset SHALL be asynchronous and active-low (RST_N).

Function
REQ-003 SHALL implement a Moore FSM with these state encodings:
- IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, RX=6, RWB=7, BR=8, JMP=9, IX=10, IWB=11
- codes 12-15 illegal; these SHALL go to IF on the next edge.

REQ-004 SHALL use these transitions:
- IF->ID when MEM_READY=1, else stay in IF.
- ID decodes OPCODE: 000000->RX; 100011 or 101011->MADR; 000100->BR; 000010->JMP; 001000->IX; any other->IF.
- MADR->MRD for lw, MADR->MWR for sw.
- MRD->MWB when MEM_READY=1, else stay.
- MWR->IF when MEM_READY=1, else stay.
- RX->RWB, IX->IWB.
- MWB, RWB, IWB, BR, JMP -> IF.

REQ-005 Per-state outputs SHALL be as listed; every unlisted output SHALL be 0.
- IF: MemRead=1, ALUSrcB=01; IRWrite=1 and PCWrite=1 only while MEM_READY=1.
- ID: ALUSrcB=11.
- MADR, IX: ALUSrcA=1, ALUSrcB=10.
- MRD: MemRead=1, IorD=1.
- MWB: RegWrite=1, MemtoReg=1.
- MWR: MemWrite=1, IorD=1.
- RX: ALUSrcA=1, ALUOp=10.
- RWB: RegWrite=1, RegDst=1.
- BR: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JMP: PCWrite=1, PCSource=10.
- IWB: RegWrite=1.

REQ-006 OPCODE SHALL be sampled only in ID (decisions in MADR use an opcode class registered at ID); OPCODE changes in other states SHALL have no effect.

REQ-007 ILLEGAL SHALL be 1 for exactly the ID cycle in which OPCODE is unsupported, and 0 otherwise.

REQ-008 Latency with MEM_READY tied to 1 SHALL be: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles; illegal opcode 2 cycles. Each MEM_READY=0 cycle in IF, MRD or MWR SHALL add exactly one cycle.

REQ-009 MemRead and MemWrite SHALL never be 1 in the same cycle; IRWrite SHALL pulse at most once per instruction.

Reset
REQ-010 While RST_N=0, STATE SHALL be IF (0) and all outputs SHALL be 0, with the reset taking effect immediately and not waiting for a clock edge.

REQ-011 When RST_N is asserted in the middle of an instruction (any state), that instruction SHALL be abandoned with no further enable pulses.

REQ-012 After RST_N rises, fetch SHALL begin in IF on the next cycle.

Configuration
REQ-013 When MCTRL_PERF_CNT_EN is defined, the block SHALL add two outputs:
- CYCLE_CNT[31:0]: increments on every clock edge out of reset.
- INSTR_CNT[31:0]: increments on each transition into IF from MWB, RWB, IWB, MWR, BR or JMP; illegal-opcode returns SHALL not increment it.
- Both SHALL reset to 0 and wrap from 0xFFFFFFFF to 0.

REQ-014 When MCTRL_PERF_CNT_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-015 lw (100011), MEM_READY=1 -> STATE 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.

REQ-016 beq (000100) then j (000010), MEM_READY=1 -> states 0,1,8,0,1,9,0; PCWriteCond=1 only in 8; PCSource=10 in 9.

REQ-017 MEM_READY=0 for 2 cycles in IF, then sw (101011) with MEM_READY=0 for 1 cycle in MWR:
- STATE holds 0 for 3 cycles, with a single IRWrite pulse;
- MWR holds for 2 cycles with MemWrite=1 throughout.

REQ-018 OPCODE=111111 -> ILLEGAL=1 for one ID cycle, STATE 0,1,0, and no RegWrite/MemWrite.

REQ-019 RST_N driven low mid-MRD -> STATE=0 and all outputs 0 within the same cycle, before the next edge; a fresh fetch starts after release.

REQ-020 With MCTRL_PERF_CNT_EN defined, lw then addi (001000) from reset, MEM_READY=1 -> CYCLE_CNT=9 and INSTR_CNT=2 on return to IF.
